// File: rtl/out_arbiter_4_pkg.sv
// Shared constants, flit field positions and FSM encodings for the output arbiter.
package out_arbiter_4_pkg;

  localparam int N_PORTS = 4;
  localparam int FLIT_W  = 67;
  localparam int BOP_BIT = 66;
  localparam int EOP_BIT = 65;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single-port build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_arbiter_4_rr_arbiter.sv
// Combinational round-robin picker: the search starts at the port after the
// last winner, so every requester is served within N_PORTS arbitrations.
module rr_arbiter
  import out_arbiter_4_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_winner,
  output logic [N_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  // Walk the ring from last_winner+1 and keep the first requesting port.
  always_comb begin
    int cand;
    cand        = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int off = 1; off <= N_PORTS; off++) begin
      cand = (int'(i_last_winner) + off) % N_PORTS;
      if (!o_any && i_req[cand]) begin
        o_any         = 1'b1;
        o_grant[cand] = 1'b1;
        o_grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/out_arbiter_4.sv
// Packet-granular output arbiter: one input buffer owns the link from the
// arbitration edge until its EOP flit is transferred; the link flit and valid
// are registered and frozen while the downstream stalls.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no owner; all inputs stalled; arbitrate on any request
// ST_LOCKED | grant held by one port; forward its flits until EOP
module out_arbiter_4 #(
  parameter int N_PORTS = out_arbiter_4_pkg::N_PORTS,
  parameter int FLIT_W  = out_arbiter_4_pkg::FLIT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS*FLIT_W-1:0] flit_in,
  input  logic [N_PORTS-1:0]        request_in,
  output logic [N_PORTS-1:0]        busy_out,
  output logic [FLIT_W-1:0]         FLIT_out,
  output logic                      VALID_out,
  input  logic                      BWDAUX1_in,
  output logic [N_PORTS-1:0]        grant_out
);

  import out_arbiter_4_pkg::*;

  localparam int IDX_W = idx_width(N_PORTS);
  // EOP keeps its distance from the MSB if the flit width is overridden.
  localparam int EOP_POS = FLIT_W - (out_arbiter_4_pkg::FLIT_W - EOP_BIT);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [N_PORTS-1:0]  r_grant;
  logic [IDX_W-1:0]    r_gidx;
  logic [IDX_W-1:0]    r_last_winner;
  logic [FLIT_W-1:0]   r_flit;
  logic                r_valid;

  logic [N_PORTS-1:0]  w_arb_grant;
  logic [IDX_W-1:0]    w_arb_idx;
  logic                w_arb_any;
  logic [FLIT_W-1:0]   w_sel_flit;
  logic                w_sel_req;
  logic                w_xfer;
  logic                w_eop_xfer;
  logic [N_PORTS-1:0]  w_busy;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req         (request_in),
    .i_last_winner (r_last_winner),
    .o_grant       (w_arb_grant),
    .o_grant_idx   (w_arb_idx),
    .o_any         (w_arb_any)
  );

  assign w_sel_flit = flit_in[r_gidx*FLIT_W +: FLIT_W];
  assign w_sel_req  = request_in[r_gidx];
  assign w_xfer     = (r_state == ST_LOCKED) && w_sel_req && !BWDAUX1_in;
  assign w_eop_xfer = w_xfer && w_sel_flit[EOP_POS];

  // Next-state: lock on any request, release on the transferred EOP flit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_arb_any)  w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_eop_xfer) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-port stall: only the owner may see a consume, and only on a transfer.
  always_comb begin
    w_busy = '1;
    if (r_state == ST_LOCKED) begin
      w_busy[r_gidx] = BWDAUX1_in | ~request_in[r_gidx];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant capture at arbitration; grant cleared and winner remembered at EOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant       <= '0;
      r_gidx        <= '0;
      r_last_winner <= IDX_W'(N_PORTS - 1);
    end else if (r_state == ST_IDLE) begin
      if (w_arb_any) begin
        r_grant <= w_arb_grant;
        r_gidx  <= w_arb_idx;
      end
    end else if (w_eop_xfer) begin
      r_grant       <= '0;
      r_last_winner <= r_gidx;
    end
  end

  // Link register: load on transfer, hold under stall, otherwise drop valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flit  <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_flit  <= w_sel_flit;
      r_valid <= 1'b1;
    end else if (!BWDAUX1_in) begin
      r_valid <= 1'b0;
    end
  end

  assign busy_out  = w_busy;
  assign FLIT_out  = r_flit;
  assign VALID_out = r_valid;
  assign grant_out = r_grant;

endmodule

// File: tb/tb_out_arbiter_4.sv
// Bench for out_arbiter_4: per-port source queues model the input buffers,
// expected link flits are queued in predicted grant order and checked as
// they appear on the link.
module tb_out_arbiter_4;
  import out_arbiter_4_pkg::*;

  localparam int NP = 4;
  localparam int FW = 67;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP*FW-1:0]  flit_in = '0;
  logic [NP-1:0]     request_in = '0;
  logic [NP-1:0]     busy_out;
  logic [FW-1:0]     FLIT_out;
  logic              VALID_out;
  logic              BWDAUX1_in = 1'b0;
  logic [NP-1:0]     grant_out;

  always #5 clk = ~clk;

  out_arbiter_4 #(.N_PORTS(NP), .FLIT_W(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flit_in    (flit_in),
    .request_in (request_in),
    .busy_out   (busy_out),
    .FLIT_out   (FLIT_out),
    .VALID_out  (VALID_out),
    .BWDAUX1_in (BWDAUX1_in),
    .grant_out  (grant_out)
  );

  logic [FW-1:0] src_q [NP][$];
  logic [FW-1:0] exp_q [$];
  logic [NP-1:0] req_en = '1;
  logic          bwd = 1'b0;
  int            checks = 0;
  int            failures = 0;
  logic [NP-1:0] s_busy;
  logic          s_bwd;
  logic          s_valid;
  logic [FW-1:0] s_flit;

  function automatic logic [FW-1:0] mk_flit(int port, int idx, int len, int tag);
    logic [FW-1:0] f;
    f = '0;
    f[BOP_BIT]  = (idx == 0);
    f[EOP_BIT]  = (idx == len - 1);
    f[64:40]    = 25'(tag * 7919 + idx * 31 + port);
    f[31:24]    = 8'(tag);
    f[15:8]     = 8'(port);
    f[7:0]      = 8'(idx);
    return f;
  endfunction

  task automatic add_pkt(int port, int len, int tag);
    for (int k = 0; k < len; k++) begin
      logic [FW-1:0] f;
      f = mk_flit(port, k, len, tag);
      src_q[port].push_back(f);
      exp_q.push_back(f);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      if (req_en[i] && src_q[i].size() > 0) begin
        request_in[i]          = 1'b1;
        flit_in[i*FW +: FW]    = src_q[i][0];
      end else begin
        request_in[i]          = 1'b0;
        flit_in[i*FW +: FW]    = '0;
      end
    end
    BWDAUX1_in = bwd;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  // One clock: drive at negedge, sample stall/consume, scoreboard after posedge.
  task automatic step();
    @(negedge clk);
    drive_inputs();
    #1;
    s_busy  = busy_out;
    s_bwd   = BWDAUX1_in;
    s_valid = VALID_out;
    s_flit  = FLIT_out;
    @(posedge clk);
    #1;
    if (s_bwd) begin
      checks++;
      if (VALID_out !== s_valid || FLIT_out !== s_flit) begin
        failures++;
        $display("FAIL stall_hold valid=%b/%b flit=%h required=%h", VALID_out, s_valid, FLIT_out, s_flit);
      end
    end else if (VALID_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flit got=%h required=none", FLIT_out);
      end else begin
        logic [FW-1:0] e;
        e = exp_q.pop_front();
        if (FLIT_out !== e) begin
          failures++;
          $display("FAIL link_flit got=%h required=%h", FLIT_out, e);
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (!s_busy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_queues();
    req_en = '1;
    bwd = 1'b0;
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    request_in = '1;
    BWDAUX1_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", VALID_out); end
    checks++; if (FLIT_out !== '0) begin failures++; $display("FAIL reset_flit got=%h required=0", FLIT_out); end
    checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b required=0000", grant_out); end
    checks++; if (busy_out !== 4'b1111) begin failures++; $display("FAIL reset_busy got=%b required=1111", busy_out); end
    @(negedge clk);
    request_in = '0;
    rst = 1'b1;
  endtask

  task automatic test_single_packet();
    add_pkt(0, 3, 1);
    step();
    checks++; if (grant_out !== 4'b0001) begin failures++; $display("FAIL single_lock_grant got=%b required=0001", grant_out); end
    checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL single_lock_valid got=%b required=0", VALID_out); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (VALID_out !== 1'b1) begin failures++; $display("FAIL single_valid_%0d got=%b required=1", k, VALID_out); end
    end
    step();
    checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL single_after_valid got=%b required=0", VALID_out); end
    checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL single_after_grant got=%b required=0000", grant_out); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int ord [5];
    ord = '{0, 1, 2, 3, 0};
    do_reset();
    for (int p = 0; p < 5; p++) add_pkt(ord[p], 1, 10 + p);
    for (int p = 0; p < 5; p++) begin
      step();
      checks++; if (grant_out !== NP'(1 << ord[p])) begin failures++; $display("FAIL rr_grant_%0d got=%b required=%b", p, grant_out, NP'(1 << ord[p])); end
      checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL rr_gap_%0d got=%b required=0", p, VALID_out); end
      step();
      checks++; if (VALID_out !== 1'b1) begin failures++; $display("FAIL rr_valid_%0d got=%b required=1", p, VALID_out); end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_stall();
    add_pkt(1, 4, 20);
    add_pkt(2, 1, 21);
    step();
    checks++; if (grant_out !== 4'b0010) begin failures++; $display("FAIL stall_grant got=%b required=0010", grant_out); end
    step();
    bwd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (s_busy !== 4'b1111) begin failures++; $display("FAIL stall_busy_%0d got=%b required=1111", k, s_busy); end
      checks++; if (VALID_out !== 1'b1) begin failures++; $display("FAIL stall_valid_%0d got=%b required=1", k, VALID_out); end
    end
    bwd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (VALID_out !== 1'b1) begin failures++; $display("FAIL stall_resume_%0d got=%b required=1", k, VALID_out); end
    end
    step();
    checks++; if (grant_out !== 4'b0100) begin failures++; $display("FAIL stall_next_grant got=%b required=0100", grant_out); end
    step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_bubble();
    add_pkt(3, 3, 30);
    step();
    checks++; if (grant_out !== 4'b1000) begin failures++; $display("FAIL bubble_grant got=%b required=1000", grant_out); end
    step();
    req_en[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL bubble_valid_%0d got=%b required=0", k, VALID_out); end
      checks++; if (grant_out !== 4'b1000) begin failures++; $display("FAIL bubble_hold_%0d got=%b required=1000", k, grant_out); end
      checks++; if (s_busy[3] !== 1'b1) begin failures++; $display("FAIL bubble_busy_%0d got=%b required=1", k, s_busy[3]); end
    end
    req_en = '1;
    repeat (2) step();
    step();
    checks++; if (VALID_out !== 1'b0 || grant_out !== 4'b0000) begin failures++; $display("FAIL bubble_end valid=%b grant=%b required=0/0000", VALID_out, grant_out); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bubble_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    add_pkt(2, 3, 40);
    step();
    step();
    @(negedge clk);
    drive_inputs();
    #1;
    rst = 1'b0;
    #1;
    checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b required=0", VALID_out); end
    checks++; if (FLIT_out !== '0) begin failures++; $display("FAIL midrst_flit got=%h required=0", FLIT_out); end
    checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL midrst_grant got=%b required=0000", grant_out); end
    checks++; if (busy_out !== 4'b1111) begin failures++; $display("FAIL midrst_busy got=%b required=1111", busy_out); end
    clear_queues();
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL midrst_release_grant got=%b required=0000", grant_out); end
    add_pkt(2, 2, 41);
    step();
    checks++; if (grant_out !== 4'b0100) begin failures++; $display("FAIL midrst_regrant got=%b required=0100", grant_out); end
    step();
    checks++; if (VALID_out !== 1'b1) begin failures++; $display("FAIL midrst_first got=%b required=1", VALID_out); end
    step();
    step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_drain got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_stall();
    test_bubble();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
